// File: rtl/lapdfd_pkg.sv
// Shared constants, symbol type and slicer for the 4-lane PAM5 decision-feedback decoder.
package lapdfd_pkg;

    localparam int NUM_LANES = 4;
    localparam int NUM_TAPS  = 14;
    localparam int SAMPLE_W  = 8;
    localparam int SYM_W     = 3;
    // Worst-case |sample - ISI| is about 3.7k, so 16 bits never wraps.
    localparam int ACC_W     = 16;

    typedef logic signed [SYM_W-1:0] symbol_t;

    localparam logic signed [ACC_W-1:0] THRESH_LO = 16'sd26;
    localparam logic signed [ACC_W-1:0] THRESH_HI = 16'sd77;

    function automatic symbol_t slice(input logic signed [ACC_W-1:0] y);
        symbol_t s;
        if (y >= THRESH_HI) begin
            s = symbol_t'(2);
        end else if (y >= THRESH_LO) begin
            s = symbol_t'(1);
        end else if (y > -THRESH_LO) begin
            s = symbol_t'(0);
        end else if (y > -THRESH_HI) begin
            s = symbol_t'(-1);
        end else begin
            s = symbol_t'(-2);
        end
        return s;
    endfunction

endpackage

// File: rtl/lapdfd_lane.sv
// One decision-feedback slicer lane: 14-deep decision history, ISI subtraction, PAM5 slicer.
module lapdfd_lane
    import lapdfd_pkg::*;
#(
    parameter int NUM_TAPS = lapdfd_pkg::NUM_TAPS,
    parameter int SAMPLE_W = lapdfd_pkg::SAMPLE_W
) (
    input  logic                              clock,
    input  logic                              reset,
    input  logic signed [SAMPLE_W-1:0]        sample,
    input  logic [NUM_TAPS-1:0][SAMPLE_W-1:0] taps,
    output symbol_t                           symbol
);

    symbol_t                 hist [NUM_TAPS];
    logic signed [ACC_W-1:0] isi;
    logic signed [ACC_W-1:0] eq;
    symbol_t                 decision;

    always_comb begin
        isi = '0;
        for (int k = 0; k < NUM_TAPS; k++) begin
            isi = isi + ACC_W'($signed(taps[k])) * ACC_W'(hist[k]);
        end
        eq       = ACC_W'(sample) - isi;
        decision = slice(eq);
    end

    // hist[0] is the most recent decision, which is also the lane's registered output.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            for (int k = 0; k < NUM_TAPS; k++) begin
                hist[k] <= '0;
            end
        end else begin
            hist[0] <= decision;
            for (int k = 1; k < NUM_TAPS; k++) begin
                hist[k] <= hist[k-1];
            end
        end
    end

    assign symbol = hist[0];

endmodule

// File: rtl/lapdfd_decoder.sv
// Top level: four independent DFE lanes sharing one tap set, outputs packed lane0 in the MSBs.
module lapdfd_decoder
    import lapdfd_pkg::*;
#(
    parameter int NUM_LANES = lapdfd_pkg::NUM_LANES,
    parameter int NUM_TAPS  = lapdfd_pkg::NUM_TAPS,
    parameter int SAMPLE_W  = lapdfd_pkg::SAMPLE_W
) (
    input  logic                         clock,
    input  logic                         reset,
    input  logic signed [SAMPLE_W-1:0]   io_rxSamples_0,
    input  logic signed [SAMPLE_W-1:0]   io_rxSamples_1,
    input  logic signed [SAMPLE_W-1:0]   io_rxSamples_2,
    input  logic signed [SAMPLE_W-1:0]   io_rxSamples_3,
    input  logic signed [SAMPLE_W-1:0]   io_taps_0,
    input  logic signed [SAMPLE_W-1:0]   io_taps_1,
    input  logic signed [SAMPLE_W-1:0]   io_taps_2,
    input  logic signed [SAMPLE_W-1:0]   io_taps_3,
    input  logic signed [SAMPLE_W-1:0]   io_taps_4,
    input  logic signed [SAMPLE_W-1:0]   io_taps_5,
    input  logic signed [SAMPLE_W-1:0]   io_taps_6,
    input  logic signed [SAMPLE_W-1:0]   io_taps_7,
    input  logic signed [SAMPLE_W-1:0]   io_taps_8,
    input  logic signed [SAMPLE_W-1:0]   io_taps_9,
    input  logic signed [SAMPLE_W-1:0]   io_taps_10,
    input  logic signed [SAMPLE_W-1:0]   io_taps_11,
    input  logic signed [SAMPLE_W-1:0]   io_taps_12,
    input  logic signed [SAMPLE_W-1:0]   io_taps_13,
    output logic [SYM_W*NUM_LANES-1:0]   io_rxSymbols,
    output logic                         io_rxValid
);

    logic signed [SAMPLE_W-1:0]        samples [NUM_LANES];
    logic [NUM_TAPS-1:0][SAMPLE_W-1:0] taps;
    symbol_t                           symbols [NUM_LANES];

    assign samples[0] = io_rxSamples_0;
    assign samples[1] = io_rxSamples_1;
    assign samples[2] = io_rxSamples_2;
    assign samples[3] = io_rxSamples_3;

    assign taps = {io_taps_13, io_taps_12, io_taps_11, io_taps_10, io_taps_9,
                   io_taps_8,  io_taps_7,  io_taps_6,  io_taps_5,  io_taps_4,
                   io_taps_3,  io_taps_2,  io_taps_1,  io_taps_0};

    for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
        lapdfd_lane #(
            .NUM_TAPS (NUM_TAPS),
            .SAMPLE_W (SAMPLE_W)
        ) u_lane (
            .clock  (clock),
            .reset  (reset),
            .sample (samples[i]),
            .taps   (taps),
            .symbol (symbols[i])
        );
    end

    always_comb begin
        io_rxSymbols = '0;
        for (int i = 0; i < NUM_LANES; i++) begin
            io_rxSymbols[SYM_W*(NUM_LANES-1-i) +: SYM_W] = symbols[i];
        end
    end

    // Every cycle after reset produces a decision, so valid is just a delayed reset release.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            io_rxValid <= 1'b0;
        end else begin
            io_rxValid <= 1'b1;
        end
    end

endmodule

// File: tb/tb_lapdfd_decoder.sv
// Directed self-checking bench for lapdfd_decoder: reset, slicer thresholds, feedback taps, ISI channel.
module tb_lapdfd_decoder;

    logic              clock;
    logic              reset;
    logic signed [7:0] samples [4];
    logic signed [7:0] taps [14];
    logic [11:0]       io_rxSymbols;
    logic              io_rxValid;

    int checks = 0;
    int errors = 0;

    lapdfd_decoder dut (
        .clock          (clock),
        .reset          (reset),
        .io_rxSamples_0 (samples[0]),
        .io_rxSamples_1 (samples[1]),
        .io_rxSamples_2 (samples[2]),
        .io_rxSamples_3 (samples[3]),
        .io_taps_0      (taps[0]),
        .io_taps_1      (taps[1]),
        .io_taps_2      (taps[2]),
        .io_taps_3      (taps[3]),
        .io_taps_4      (taps[4]),
        .io_taps_5      (taps[5]),
        .io_taps_6      (taps[6]),
        .io_taps_7      (taps[7]),
        .io_taps_8      (taps[8]),
        .io_taps_9      (taps[9]),
        .io_taps_10     (taps[10]),
        .io_taps_11     (taps[11]),
        .io_taps_12     (taps[12]),
        .io_taps_13     (taps[13]),
        .io_rxSymbols   (io_rxSymbols),
        .io_rxValid     (io_rxValid)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic applyStimulus(input int s0, input int s1, input int s2, input int s3);
        samples[0] = 8'(s0);
        samples[1] = 8'(s1);
        samples[2] = 8'(s2);
        samples[3] = 8'(s3);
        @(posedge clock);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [11:0] expSym, input logic expValid);
        checks++;
        assert (io_rxSymbols === expSym) else begin
            errors++;
            $error("[TB] FAIL %s symbols got %h expected %h", tag, io_rxSymbols, expSym);
        end
        checks++;
        assert (io_rxValid === expValid) else begin
            errors++;
            $error("[TB] FAIL %s valid got %b expected %b", tag, io_rxValid, expValid);
        end
    endtask

    function automatic int pam5Level(input int sym);
        case (sym)
            -2:      return -103;
            -1:      return -52;
            1:       return 51;
            2:       return 101;
            default: return 0;
        endcase
    endfunction

    int          sweepIn  [10] = '{25, 26, 76, 77, -25, -26, -76, -77, 127, -128};
    int          sweepExp [10] = '{0, 1, 1, 2, 0, -1, -1, -2, 2, -2};
    int          tx [4][14];
    int          sym;
    int          smp;
    logic [11:0] expWord;

    initial begin
        reset = 1'b0;
        for (int i = 0; i < 4; i++) samples[i] = '0;
        for (int k = 0; k < 14; k++) taps[k] = '0;

        repeat (3) @(posedge clock);
        #1;
        checkOutput("reset_hold", 12'h000, 1'b0);

        @(negedge clock) reset = 1'b1;
        @(posedge clock);
        #1;
        checkOutput("first_valid", 12'h000, 1'b1);

        applyStimulus(101, -52, 0, 51);
        checkOutput("nominal_levels", 12'h5C1, 1'b1);

        for (int i = 0; i < 10; i++) begin
            applyStimulus(sweepIn[i], 0, 0, 0);
            expWord = {3'(sweepExp[i]), 9'b0};
            checkOutput($sformatf("sweep_%0d", sweepIn[i]), expWord, 1'b1);
        end

        // Tap 0 = 25: last sweep decision was -2, so 101 + 50 still slices to +2, then 101 - 50 = 51.
        taps[0] = 8'sd25;
        applyStimulus(101, 0, 0, 0);
        checkOutput("tap0_prime", 12'h400, 1'b1);
        applyStimulus(101, 0, 0, 0);
        checkOutput("tap0_feedback", 12'h200, 1'b1);

        reset = 1'b0;
        #1;
        checkOutput("async_reset", 12'h000, 1'b0);
        taps[0]  = 8'sd0;
        taps[13] = 8'sd25;
        for (int i = 0; i < 4; i++) samples[i] = '0;
        @(negedge clock) reset = 1'b1;
        @(posedge clock);
        #1;
        checkOutput("tap13_idle", 12'h000, 1'b1);
        applyStimulus(101, 0, 0, 0);
        checkOutput("tap13_prime", 12'h400, 1'b1);
        repeat (13) applyStimulus(0, 0, 0, 0);
        checkOutput("tap13_quiet", 12'h000, 1'b1);
        applyStimulus(101, 0, 0, 0);
        checkOutput("tap13_feedback", 12'h200, 1'b1);

        taps = '{8'sd7, -8'sd5, 8'sd3, -8'sd11, 8'sd2, 8'sd9, -8'sd4,
                 8'sd6, -8'sd8, 8'sd1, 8'sd12, -8'sd3, 8'sd5, -8'sd7};
        for (int c = 0; c < 20; c++) begin
            applyStimulus(int'($urandom_range(0, 255)), int'($urandom_range(0, 255)),
                          int'($urandom_range(0, 255)), int'($urandom_range(0, 255)));
        end
        reset = 1'b0;
        repeat (2) @(posedge clock);
        #1;
        checkOutput("midstream_reset", 12'h000, 1'b0);
        for (int i = 0; i < 4; i++) samples[i] = 8'sd51;
        @(negedge clock) reset = 1'b1;
        @(posedge clock);
        #1;
        checkOutput("post_reset_clean", 12'h249, 1'b1);

        // Known ISI channel; sum|taps| = 7 keeps level + ISI + noise inside 8-bit range.
        reset = 1'b0;
        for (int k = 0; k < 14; k++) taps[k] = '0;
        taps[0]  = 8'sd3;
        taps[1]  = -8'sd2;
        taps[5]  = 8'sd1;
        taps[13] = 8'sd1;
        for (int i = 0; i < 4; i++) samples[i] = '0;
        for (int l = 0; l < 4; l++) for (int k = 0; k < 14; k++) tx[l][k] = 0;
        @(negedge clock) reset = 1'b1;
        @(posedge clock);
        #1;
        checkOutput("channel_start", 12'h000, 1'b1);

        for (int c = 0; c < 40; c++) begin
            expWord = '0;
            for (int l = 0; l < 4; l++) begin
                sym = int'($urandom_range(0, 4)) - 2;
                smp = pam5Level(sym) + int'($urandom_range(0, 20)) - 10;
                for (int k = 0; k < 14; k++) smp += int'(taps[k]) * tx[l][k];
                samples[l] = 8'(smp);
                expWord[3*(3-l) +: 3] = 3'(sym);
                for (int k = 13; k > 0; k--) tx[l][k] = tx[l][k-1];
                tx[l][0] = sym;
            end
            @(posedge clock);
            #1;
            checkOutput($sformatf("channel_%0d", c), expWord, 1'b1);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/lapdfd_decoder.md
LAPDFD_DECODER -- requirements
Module: lapdfd

Interface
REQ-001 Parameter NUM_LANES, default 4, number of parallel PAM5 lanes.
REQ-002 Parameter NUM_TAPS, default 14, number of feedback taps.
REQ-003 Parameter SAMPLE_W, default 8, sample and tap width.
REQ-004 clock  input  1  single clock; all state updates on its rising edge.
REQ-005 reset  input  1  asynchronous, active-low reset (asserted when 0).
REQ-006 io_rxSamples_0..io_rxSamples_3  input  8 each  signed two's-complement received samples, one per lane per cycle.
REQ-007 io_taps_0..io_taps_13  input  8 each  signed feedback coefficients, shared by all lanes, quasi-static.
REQ-008 io_rxSymbols  output  12  decided symbols, 3-bit two's complement each: lane0 [11:9], lane1 [8:6], lane2 [5:3], lane3 [2:0].
REQ-009 io_rxValid  output  1  high when io_rxSymbols holds a decision.

Function
REQ-010 Each lane SHALL run an independent decision-feedback slicer; lanes share only the tap values.
REQ-011 Each lane SHALL keep a history of its last 14 decided symbols a[n-1]..a[n-14], each in {-2,-1,0,1,2}.
REQ-012 Feedback SHALL be ISI = sum over k=0..13 of io_taps_k * a[n-1-k]; tap 0 multiplies the most recent decision.
REQ-013 Equalized value SHALL be y = sample - ISI, computed in at least 14-bit signed arithmetic with no truncation or saturation.
REQ-014 Slicer SHALL map y>=77 -> +2; 26<=y<=76 -> +1; -25<=y<=25 -> 0; -76<=y<=-26 -> -1; y<=-77 -> -2.
REQ-015 Nominal PAM5 sample levels are -103, -52, 0, 51, 101; each SHALL slice to -2, -1, 0, 1, 2 with zero taps.
REQ-016 Decision and history update SHALL be registered: samples present before rising edge n appear on io_rxSymbols after edge n (1-cycle latency).
REQ-017 The decision registered at edge n SHALL become a[n-1] for the samples of the following cycle (history shift at every edge).
REQ-018 io_rxValid SHALL be 0 during reset and 1 from the first rising edge after reset deassertion, then remain 1 every cycle.
REQ-019 There is no input handshake; a new sample set is consumed every cycle.
REQ-020 Tap changes SHALL take effect on the next decision without a flush.

Reset
REQ-021 While reset=0: io_rxSymbols=0, io_rxValid=0, all history entries=0, asynchronously.
REQ-022 Reset asserted mid-stream SHALL discard all history; the first post-reset decision SHALL see zero ISI.

Structure
REQ-023 A shared package SHALL hold NUM_LANES, NUM_TAPS, the 3-bit symbol typedef, and slicer thresholds 26/77.
REQ-024 One sub-module, lapdfd_lane, SHALL implement the per-lane history, ISI sum and slicer; lapdfd instantiates 4 and packs outputs.

Verification
REQ-025 Reset held low -> io_rxSymbols=0x000, io_rxValid=0; after release, io_rxValid=1 at the first edge.
REQ-026 Taps all 0, samples (101,-52,0,51) -> next cycle io_rxSymbols = 2,-1,0,1 = 0x5C1.
REQ-027 Taps 0, lane0 sweep 25,26,76,77,-25,-26,-76,-77,127,-128 -> 0,1,1,2,0,-1,-1,-2,2,-2.
REQ-028 Tap0=25, lane0 decides +2, next sample 101 -> y=51 -> +1; same with tap13=25 needs +2 decided 14 cycles earlier.
REQ-029 Run random symbols with taps, assert reset mid-stream, release, send sample 51 on all lanes -> 0x249 (all +1, history cleared).
REQ-030 Random PAM5 stream through known 14-tap ISI channel with noise below 25 -> decisions match transmitted symbols after 1-cycle latency.
